// File: rtl/fetch_bht_pkg.sv
// Shared constants and helpers for the fetch stage and its branch history table.
package fetch_bht_pkg;

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT_DEFAULT = 2'b01;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Table of 2-bit counters: async reset, one combinational read, one write port.
// FETCH_BHT_BYPASS_EN forwards a same-cycle write to the read port.
module fetch_bht
  import fetch_bht_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter logic [CNT_W-1:0] CNT_INIT = CNT_INIT_DEFAULT
) (
  input  logic                stg_clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CNT_W-1:0]    rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [CNT_W-1:0]    wr_cnt
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [CNT_W-1:0] cnt_q [Entries];

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_cnt;
    end
  end

  always_comb begin
`ifdef FETCH_BHT_BYPASS_EN
    rd_cnt = (wr_en && (wr_idx == rd_idx)) ? wr_cnt : cnt_q[rd_idx];
`else
    rd_cnt = cnt_q[rd_idx];
`endif
  end

endmodule

// File: rtl/fetch_bht_stage.sv
// Fetch stage: PC register, B/JAL predecode with counter-based prediction, decode-side latch.
// Optional macro FETCH_BHT_BYPASS_EN: same-cycle counter update is visible to the lookup.
module fetch_bht_stage
  import fetch_bht_pkg::*;
#(
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [CNT_W-1:0] CNT_INIT = CNT_INIT_DEFAULT
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic             stg_ena,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [CNT_W-1:0] upd_counter,
  output logic [31:0]      pc_out,
  output logic [31:0]      instr_out,
  output logic             valid_out,
  output logic             branch_prediction_out,
  output logic [CNT_W-1:0] counter_out
);

  logic [31:0]             pc_q, pc_d;
  logic [BHT_IDX_BITS-1:0] lookup_idx, upd_idx;
  logic [CNT_W-1:0]        lookup_cnt, upd_cnt_new;
  logic                    pred;
  logic [31:0]             target;
  logic                    upd_pc_unused;

  assign imem_addr     = pc_q;
  assign lookup_idx    = pc_q[BHT_IDX_BITS+1:2];
  assign upd_idx       = upd_pc[BHT_IDX_BITS+1:2];
  assign upd_cnt_new   = upd_taken ? sat_inc(upd_counter) : sat_dec(upd_counter);
  assign upd_pc_unused = ^{upd_pc[31:BHT_IDX_BITS+2], upd_pc[1:0]};

  fetch_bht #(
    .IDX_BITS (BHT_IDX_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .stg_clk (stg_clk),
    .reset   (reset),
    .rd_idx  (lookup_idx),
    .rd_cnt  (lookup_cnt),
    .wr_en   (upd_valid),
    .wr_idx  (upd_idx),
    .wr_cnt  (upd_cnt_new)
  );

  always_comb begin
    pred   = 1'b0;
    target = pc_q + 32'd4;
    case (imem_rdata[6:0])
      OPC_BRANCH: begin
        pred   = lookup_cnt[1];
        target = pc_q + imm_b(imem_rdata);
      end
      OPC_JAL: begin
        pred   = 1'b1;
        target = pc_q + imm_j(imem_rdata);
      end
      default: ;
    endcase
    pc_d = pred ? target : pc_q + 32'd4;
  end

  // Redirect wins over stall; the decode latch still captures this cycle, marked as a bubble.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      pc_q                  <= RESET_PC;
      pc_out                <= '0;
      instr_out             <= '0;
      valid_out             <= 1'b0;
      branch_prediction_out <= 1'b0;
      counter_out           <= '0;
    end else if (redirect_valid) begin
      pc_q                  <= redirect_pc;
      pc_out                <= pc_q;
      instr_out             <= imem_rdata;
      valid_out             <= 1'b0;
      branch_prediction_out <= pred;
      counter_out           <= lookup_cnt;
    end else if (stg_ena) begin
      pc_q                  <= pc_d;
      pc_out                <= pc_q;
      instr_out             <= imem_rdata;
      valid_out             <= 1'b1;
      branch_prediction_out <= pred;
      counter_out           <= lookup_cnt;
    end
  end

endmodule

// File: tb/tb_fetch_bht_stage.sv
// Directed bench for fetch_bht_stage with an expected-result queue.
module tb_fetch_bht_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0200_0063;  // beq x0,x0,+0x20
  localparam logic [31:0] JAL = 32'hFF9F_F06F;  // jal x0,-8

  logic        stg_clk = 1'b0;
  logic        reset;
  logic        stg_ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [1:0]  upd_counter;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        branch_prediction_out;
  logic [1:0]  counter_out;

  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        bp;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb [$];

  fetch_bht_stage dut (
    .stg_clk               (stg_clk),
    .reset                 (reset),
    .stg_ena               (stg_ena),
    .imem_addr             (imem_addr),
    .imem_rdata            (imem_rdata),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .upd_valid             (upd_valid),
    .upd_pc                (upd_pc),
    .upd_taken             (upd_taken),
    .upd_counter           (upd_counter),
    .pc_out                (pc_out),
    .instr_out             (instr_out),
    .valid_out             (valid_out),
    .branch_prediction_out (branch_prediction_out),
    .counter_out           (counter_out)
  );

  always #5 stg_clk = ~stg_clk;

  always_comb imem_rdata = mem[imem_addr[8:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expectation, clock once, then pop and compare at the falling edge.
  task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                      input logic [31:0] instr, input logic valid, input logic bp,
                      input logic [1:0] cnt);
    exp_t e;
    sb.push_back('{tag, addr, pc, instr, valid, bp, cnt});
    @(posedge stg_clk);
    @(negedge stg_clk);
    e = sb.pop_front();
    chk({e.tag, ".addr"}, imem_addr, e.addr);
    chk({e.tag, ".pc"}, pc_out, e.pc);
    chk({e.tag, ".instr"}, instr_out, e.instr);
    chk({e.tag, ".valid"}, {31'd0, valid_out}, {31'd0, e.valid});
    chk({e.tag, ".bp"}, {31'd0, branch_prediction_out}, {31'd0, e.bp});
    chk({e.tag, ".cnt"}, {30'd0, counter_out}, {30'd0, e.cnt});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".addr"}, imem_addr, 32'h0);
    chk({tag, ".pc"}, pc_out, 32'h0);
    chk({tag, ".instr"}, instr_out, 32'h0);
    chk({tag, ".valid"}, {31'd0, valid_out}, 32'h0);
    chk({tag, ".bp"}, {31'd0, branch_prediction_out}, 32'h0);
    chk({tag, ".cnt"}, {30'd0, counter_out}, 32'h0);
  endtask

  logic [31:0] col_addr;
  logic        col_bp;
  logic [1:0]  col_cnt;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    mem[4] = BEQ;  // 0x10
    mem[9] = BEQ;  // 0x24
    reset = 1'b1; stg_ena = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_counter = '0;
    repeat (2) @(negedge stg_clk);
    chk_reset_state("rst0");
    reset = 1'b0;

    // Straight-line stream
    stg_ena = 1'b1;
    chk("seq.addr0", imem_addr, 32'h0);
    step("seq0", 32'h4, 32'h0, NOP, 1'b1, 1'b0, 2'b01);
    step("seq1", 32'h8, 32'h4, NOP, 1'b1, 1'b0, 2'b01);

    // Training a BEQ at 0x10
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step("rd10", 32'h10, 32'h8, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0;
    step("beq0", 32'h14, 32'h10, BEQ, 1'b1, 1'b0, 2'b01);
    stg_ena = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_counter = 2'b01;
    step("upd1", 32'h14, 32'h10, BEQ, 1'b1, 1'b0, 2'b01);
    upd_counter = 2'b10;
    step("upd2", 32'h14, 32'h10, BEQ, 1'b1, 1'b0, 2'b01);
    upd_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step("rd10b", 32'h10, 32'h14, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0; stg_ena = 1'b1;
    step("beq1", 32'h30, 32'h10, BEQ, 1'b1, 1'b1, 2'b11);

    // JAL at 0x8, taken regardless of counter
    mem[2] = JAL;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step("rd08", 32'h8, 32'h30, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0;
    step("jal", 32'h0, 32'h8, JAL, 1'b1, 1'b1, 2'b01);

    // Redirect while stalled
    stg_ena = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step("rdstall", 32'h100, 32'h0, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0;
    step("stall", 32'h100, 32'h0, NOP, 1'b0, 1'b0, 2'b01);

    // Saturation at both ends
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_counter = 2'b11;
    step("sat_hi", 32'h100, 32'h0, NOP, 1'b0, 1'b0, 2'b01);
    upd_pc = 32'h20; upd_taken = 1'b0; upd_counter = 2'b00;
    step("sat_lo", 32'h100, 32'h0, NOP, 1'b0, 1'b0, 2'b01);
    upd_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step("rd10c", 32'h10, 32'h100, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0; stg_ena = 1'b1;
    step("sat_hi_rd", 32'h30, 32'h10, BEQ, 1'b1, 1'b1, 2'b11);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step("rd20", 32'h20, 32'h30, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0;
    step("sat_lo_rd", 32'h24, 32'h20, NOP, 1'b1, 1'b0, 2'b00);

    // Update and lookup collide on the BEQ at 0x24 (stored 01, new 10)
`ifdef FETCH_BHT_BYPASS_EN
    col_addr = 32'h44; col_bp = 1'b1; col_cnt = 2'b10;
`else
    col_addr = 32'h28; col_bp = 1'b0; col_cnt = 2'b01;
`endif
    upd_valid = 1'b1; upd_pc = 32'h24; upd_taken = 1'b1; upd_counter = 2'b01;
    step("collide", col_addr, 32'h24, BEQ, 1'b1, col_bp, col_cnt);
    upd_valid = 1'b0; stg_ena = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h24;
    step("rd24", 32'h24, col_addr, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0; stg_ena = 1'b1;
    step("after_col", 32'h44, 32'h24, BEQ, 1'b1, 1'b1, 2'b10);

    // Asynchronous reset mid-run with PC = 0x40
    stg_ena = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step("rd40", 32'h40, 32'h44, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_state("rst_mid");
    @(negedge stg_clk);
    reset = 1'b0; stg_ena = 1'b1;
    step("post_rst", 32'h4, 32'h0, NOP, 1'b1, 1'b0, 2'b01);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step("rd10d", 32'h10, 32'h4, NOP, 1'b0, 1'b0, 2'b01);
    redirect_valid = 1'b0;
    step("tbl_rst", 32'h14, 32'h10, BEQ, 1'b1, 1'b0, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_bht_stage.md
Name: fetch_bht_stage

Overview:
- Instruction-fetch stage: owns the PC, drives the instruction-memory address, and predicts branches with a table of 2-bit saturating counters.
- Registers {pc, instr, valid, branch_prediction, counter} toward decode; these are the values the decode latch later carries as pc/valid/branch_prediction/counter.
- Accepts counter updates and PC redirects from execute.

Parameters:
- BHT_IDX_BITS, 6: table index width; 2^BHT_IDX_BITS entries.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- CNT_INIT, 2'b01: counter value of every entry after reset (weakly not-taken).

Ports:
- stg_clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stg_ena  in  1  advance enable; 0 = stall.
- imem_addr  out  32  instruction address; combinational copy of the PC register.
- imem_rdata  in  32  instruction at imem_addr, same cycle (combinational memory).
- redirect_valid  in  1  execute mispredict/flush request.
- redirect_pc  in  32  corrected PC.
- upd_valid  in  1  counter update strobe.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_counter  in  2  counter value that was carried with that branch.
- pc_out  out  32  registered fetch PC.
- instr_out  out  32  registered instruction.
- valid_out  out  1  1 = real instruction, 0 = bubble.
- branch_prediction_out  out  1  1 = predicted taken.
- counter_out  out  2  counter value read for this PC.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - PC = RESET_PC.
  - pc_out, instr_out, valid_out, branch_prediction_out, counter_out = 0.
  - All table entries = CNT_INIT.
- Index: idx = pc[BHT_IDX_BITS+1:2]; pc[1:0] ignored. Lookup is combinational from the PC register.
- Predecode of imem_rdata[6:0]:
  - 1100011 (B-type): pred = cnt[1]; target = pc + sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - 1101111 (JAL): pred = 1 regardless of counter; target = pc + sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - Any other opcode: pred = 0.
- Adds are 32-bit modulo 2^32; wrap-around is silent.
- Next-PC priority on each rising edge:
  1. redirect_valid: PC <= redirect_pc; valid_out <= 0; the other outputs load the current-cycle values. Applies even when stg_ena = 0.
  2. else stg_ena = 1: PC <= (pred ? target : PC+4); pc_out <= PC; instr_out <= imem_rdata; valid_out <= 1; branch_prediction_out <= pred; counter_out <= table[idx].
  3. else (stall): PC and all outputs hold.
- Latency: outputs describe the address presented one cycle earlier.
- Counter update (any cycle, independent of stg_ena and redirect):
  - On upd_valid, table[upd_pc idx] <= upd_taken ? sat_inc(upd_counter) : sat_dec(upd_counter).
  - Saturates at 2'b11 and 2'b00.
- Same-cycle update and lookup to the same index: lookup sees the old stored value (write after read), unless the optional feature below is enabled.
- No internal state machine beyond PC, output registers and table.

Optional Feature:
- Macro: FETCH_BHT_BYPASS_EN.
- Defined: when upd_valid and the update index equals the lookup idx in the same cycle, the lookup uses the new counter value (forwarded) for both pred and counter_out.
- Undefined: the lookup uses the stored value; the update is visible from the next cycle.

Decomposition:
- Shared package holds:
  - opcode constants OPC_BRANCH = 7'b1100011 and OPC_JAL = 7'b1101111.
  - 2-bit counter width constant and CNT_INIT default.
  - functions sat_inc, sat_dec, imm_b and imm_j.
- One sub-module, fetch_bht: table storage with async reset, one combinational read port and one write port; contains the bypass logic under FETCH_BHT_BYPASS_EN.

Test Plan:
1. Reset: assert reset mid-run with PC = 0x40 → imem_addr = 0x0, all outputs 0; after release, first fetch gives counter_out = 2'b01.
2. Straight-line: NOP stream with stg_ena = 1 → imem_addr 0x0, 0x4, 0x8; pc_out lags by one cycle; valid_out = 1.
3. Training: BEQ at 0x10 with imm +0x20.
   - First fetch → pred 0, next addr 0x14.
   - Updates (upd_counter 01, taken) then (10, taken) → entry 2'b11.
   - Refetch → pred 1, next addr 0x30, counter_out 2'b11.
4. JAL at 0x8 with imm −8 → next addr 0x0, branch_prediction_out = 1 whatever the counter value.
5. Redirect during stall: stg_ena = 0, redirect_valid = 1, redirect_pc = 0x100 → next cycle imem_addr = 0x100, valid_out = 0.
6. Saturation and collision:
   - upd_counter 11 taken → entry stays 11; upd_counter 00 not-taken → entry stays 00.
   - Update and fetch to the same index in one cycle → counter_out shows the old value (macro undefined) or the new value (FETCH_BHT_BYPASS_EN defined).
